// File: rtl/match_sequencer_if.sv
// Signal bundle between the match sequencer and its environment (frame strobe,
// buttons, game_logic status in; serve/status outputs out).
interface match_sequencer_if;
  logic       frame_pulse;
  logic       p1_btn_action;
  logic       p2_btn_action;
  logic       ball_out_p1;
  logic       ball_out_p2;
  logic [1:0] p1_lives;
  logic [1:0] p2_lives;
  logic       serve_action;
  logic       server;
  logic [2:0] seq_state;
  logic [8:0] timer;
  logic [1:0] winner;
  logic       paddle_enable;
  logic       blink;

  // Environment side: drives strobe and player/game inputs, observes sequencer
  modport master (
    output frame_pulse, p1_btn_action, p2_btn_action,
    output ball_out_p1, ball_out_p2, p1_lives, p2_lives,
    input  serve_action, server, seq_state, timer, winner, paddle_enable, blink
  );

  // Sequencer side
  modport slave (
    input  frame_pulse, p1_btn_action, p2_btn_action,
    input  ball_out_p1, ball_out_p2, p1_lives, p2_lives,
    output serve_action, server, seq_state, timer, winner, paddle_enable, blink
  );
endinterface

// File: rtl/match_sequencer.sv
// Frame-rate match controller: attract / ready / countdown / serve / play /
// point-pause / game-over sequencing, serve generation, server and winner tracking.
// Optional feature macro: MATCH_SEQUENCER_AUTO_SERVE_EN (auto-serve after idle READY).
module match_sequencer #(
  parameter int unsigned SERVE_DELAY_FRAMES = 60,
  parameter int unsigned POINT_PAUSE_FRAMES = 90,
  parameter int unsigned GAMEOVER_FRAMES    = 300,
  parameter int unsigned AUTO_SERVE_FRAMES  = 240
) (
  input logic              clk,
  input logic              nRst,
  match_sequencer_if.slave bus
);

  localparam int unsigned TIMER_W = 9;
  localparam int unsigned BLINK_W = 4;

`ifdef MATCH_SEQUENCER_AUTO_SERVE_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [TIMER_W-1:0] POINT_LOAD = TIMER_W'(POINT_PAUSE_FRAMES - 1);
  localparam logic [TIMER_W-1:0] OVER_LOAD  = TIMER_W'(GAMEOVER_FRAMES - 1);
  // READY timer only counts when auto-serve is built in; otherwise it sits at 0
  localparam logic [TIMER_W-1:0] READY_LOAD =
    AUTO_EN ? TIMER_W'(AUTO_SERVE_FRAMES - 1) : '0;
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  typedef enum logic [2:0] {
    ST_ATTRACT   = 3'd0,
    ST_READY     = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_SERVE     = 3'd3,
    ST_PLAYING   = 3'd4,
    ST_POINT     = 3'd5,
    ST_GAMEOVER  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               server_q, server_d;
  logic [1:0]         winner_q, winner_d;
  logic               p1_prev_q, p1_prev_d;
  logic               p2_prev_q, p2_prev_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               serve_q, serve_d;
  logic               paddle_q, paddle_d;

  logic               p1_press, p2_press, server_press, timer_zero;
  logic               loser_p2;
  logic [1:0]         loser_lives;

  // Next-state, timer, server/winner and blink decisions; all gated by frame_pulse
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    server_d     = server_q;
    winner_d     = winner_q;
    p1_prev_d    = p1_prev_q;
    p2_prev_d    = p2_prev_q;
    blink_cnt_d  = blink_cnt_q;
    blink_d      = blink_q;
    p1_press     = bus.frame_pulse & bus.p1_btn_action & ~p1_prev_q;
    p2_press     = bus.frame_pulse & bus.p2_btn_action & ~p2_prev_q;
    server_press = server_q ? p2_press : p1_press;
    timer_zero   = (timer_q == '0);
    loser_p2     = ~bus.ball_out_p1;
    loser_lives  = loser_p2 ? bus.p2_lives : bus.p1_lives;

    if (bus.frame_pulse) begin
      p1_prev_d = bus.p1_btn_action;
      p2_prev_d = bus.p2_btn_action;
    end

    case (state_q)
      ST_ATTRACT: begin
        if (p1_press | p2_press) begin
          state_d  = ST_READY;
          server_d = ~p1_press;
          timer_d  = READY_LOAD;
        end
      end
      ST_READY: begin
        if (server_press) begin
          state_d = ST_COUNTDOWN;
          timer_d = SERVE_LOAD;
        end
`ifdef MATCH_SEQUENCER_AUTO_SERVE_EN
        else if (bus.frame_pulse) begin
          if (timer_zero) begin
            state_d = ST_COUNTDOWN;
            timer_d = SERVE_LOAD;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
`endif
      end
      ST_COUNTDOWN: begin
        if (bus.frame_pulse) begin
          if (timer_zero) state_d = ST_SERVE;
          else            timer_d = timer_q - TIMER_ONE;
        end
      end
      ST_SERVE: begin
        if (bus.frame_pulse) state_d = ST_PLAYING;
      end
      ST_PLAYING: begin
        if (bus.frame_pulse && (bus.ball_out_p1 || bus.ball_out_p2)) begin
          server_d = loser_p2;
          if (loser_lives == 2'd0) begin
            winner_d = loser_p2 ? 2'b01 : 2'b10;
            state_d  = ST_GAMEOVER;
            timer_d  = OVER_LOAD;
          end else begin
            state_d = ST_POINT;
            timer_d = POINT_LOAD;
          end
        end
      end
      ST_POINT: begin
        if (bus.frame_pulse) begin
          if (timer_zero) begin
            state_d = ST_READY;
            timer_d = READY_LOAD;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
      end
      ST_GAMEOVER: begin
        if (bus.frame_pulse) begin
          if (timer_zero) begin
            state_d  = ST_ATTRACT;
            winner_d = 2'b00;
            server_d = 1'b0;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
      end
      default: begin
        state_d  = ST_ATTRACT;
        timer_d  = '0;
        server_d = 1'b0;
        winner_d = 2'b00;
      end
    endcase

    // Blink counter runs only while staying in READY; cleared everywhere else
    if (state_d != ST_READY) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (state_q == ST_READY && bus.frame_pulse) begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      if (blink_cnt_q == '1) blink_d = ~blink_q;
    end

    serve_d  = (state_d == ST_SERVE);
    paddle_d = (state_d == ST_COUNTDOWN) || (state_d == ST_SERVE) || (state_d == ST_PLAYING);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= ST_ATTRACT;
      timer_q     <= '0;
      server_q    <= 1'b0;
      winner_q    <= 2'b00;
      p1_prev_q   <= 1'b0;
      p2_prev_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      serve_q     <= 1'b0;
      paddle_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      server_q    <= server_d;
      winner_q    <= winner_d;
      p1_prev_q   <= p1_prev_d;
      p2_prev_q   <= p2_prev_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      serve_q     <= serve_d;
      paddle_q    <= paddle_d;
    end
  end

  assign bus.seq_state     = state_q;
  assign bus.timer         = timer_q;
  assign bus.server        = server_q;
  assign bus.winner        = winner_q;
  assign bus.serve_action  = serve_q;
  assign bus.paddle_enable = paddle_q;
  assign bus.blink         = blink_q;

endmodule

// File: doc/match_sequencer.md
# match_sequencer

Frame-rate match controller that sits between the player buttons and `game_logic`. It sequences a match through attract, serve-ready, countdown, serve, play, point-pause and game-over phases. It generates the single serve action that `game_logic` samples, tracks who serves, and reports the winner. All decisions are taken on `frame_pulse`, so the block runs in lockstep with ball and paddle updates.

## Interface
Parameters:
- `SERVE_DELAY_FRAMES`, 60: countdown length in frames, 1..511.
- `POINT_PAUSE_FRAMES`, 90: pause after a non-final point, 1..511.
- `GAMEOVER_FRAMES`, 300: game-over hold time, 1..511.
- `AUTO_SERVE_FRAMES`, 240: idle frames in READY before auto-serve. Only used with `MATCH_SEQUENCER_AUTO_SERVE_EN`.

Ports:
- `clk` in 1: system clock.
- `nRst` in 1: reset. One clock; reset is synchronous and active-low.
- `frame_pulse` in 1: one-cycle strobe per frame, shared with `game_logic`.
- `p1_btn_action` in 1: raw player 1 action button, level.
- `p2_btn_action` in 1: raw player 2 action button, level.
- `ball_out_p1` in 1: ball lost on player 1 side (from `game_logic`).
- `ball_out_p2` in 1: ball lost on player 2 side.
- `p1_lives` in 2: player 1 lives (from `game_logic`), pre-decrement value at the sampling pulse.
- `p2_lives` in 2: player 2 lives, same convention.
- `serve_action` out 1: drives the `game_logic` action input.
- `server` out 1: 0 = player 1 serves, 1 = player 2 serves.
- `seq_state` out 3: current state encoding.
- `timer` out 9: remaining frames in the current timed state.
- `winner` out 2: 00 none, 01 player 1, 10 player 2.
- `paddle_enable` out 1: high in COUNTDOWN, SERVE and PLAYING.
- `blink` out 1: toggles every 16 frames while in READY; 0 in all other states.

## Operation
- Press detection: `p*_prev` registers are updated with the button levels on every `frame_pulse`. A press is `btn & ~prev` sampled at `frame_pulse`. `prev` resets to 0.
- States, with encoding:
  - ATTRACT=0: any press → READY. `server` = presser; player 1 wins if both press.
  - READY=1: a press by the current server → COUNTDOWN with `timer`=SERVE_DELAY_FRAMES-1. A press by the non-server is ignored.
  - COUNTDOWN=2: `timer` decrements on each pulse. A pulse with `timer`==0 → SERVE.
  - SERVE=3: `serve_action`=1 for the whole state. The next pulse → PLAYING. `game_logic` therefore sees action high on exactly one `frame_pulse`.
  - PLAYING=4: on a pulse with `ball_out_p1` (which has priority over `ball_out_p2`), the loser is player 1; otherwise with `ball_out_p2`, the loser is player 2.
    - If the loser's lives==0: `winner` = the other player, `timer`=GAMEOVER_FRAMES-1, → GAMEOVER.
    - Otherwise: `timer`=POINT_PAUSE_FRAMES-1, → POINT.
    - In both cases `server` = the loser.
  - POINT=5: `timer` decrements on each pulse. At 0 → READY.
  - GAMEOVER=6: `timer` decrements on each pulse; presses are ignored. At 0 → ATTRACT, `winner`=00, `server`=0.
- Encoding 7 is unreachable and recovers to ATTRACT on the next clock.
- Between pulses, all state, the timer and the `prev` registers hold.

## Timing
- Reset values, synchronous on a clock edge with `nRst`=0:
  - `seq_state`=ATTRACT, `timer`=0, `server`=0, `winner`=00.
  - `serve_action`=0, `paddle_enable`=0, `blink`=0, blink counter 0.
- All outputs are registered or decoded from registered state. Transitions appear the cycle after the `frame_pulse` cycle.
- `nRst` low mid-match returns to ATTRACT on that edge, regardless of `frame_pulse`.
- Simultaneous `ball_out_p1` and `ball_out_p2`: player 1 is the loser.
- `ball_out_*` outside PLAYING is ignored.
- `timer` never wraps: decrements only when non-zero, and the transition fires on the pulse that sees 0.
- The blink counter is 4 bits, clears on entry to READY, and `blink` toggles when the counter wraps 15→0.

## Configuration
- `MATCH_SEQUENCER_AUTO_SERVE_EN` defined:
  - READY loads `timer`=AUTO_SERVE_FRAMES-1 on entry and decrements per pulse.
  - At 0 it moves to COUNTDOWN as if the server had pressed.
  - A server press still takes effect immediately.
- Not defined: READY waits indefinitely and `timer` holds 0 in READY.

## Test plan
- Reset, then player 2 presses: → READY with `server`=1. Player 1 pressing is ignored. Player 2 presses → COUNTDOWN with `timer`=59.
- Countdown with defaults: `serve_action` is high at exactly one `frame_pulse`, the 61st pulse after the press pulse. Then PLAYING with `paddle_enable`=1.
- In PLAYING, `ball_out_p2`=1 with `p2_lives`=2: → POINT, `timer`=89, `server`=1. After 90 pulses → READY.
- `ball_out_p1`=`ball_out_p2`=1 with `p1_lives`=0: `winner`=10 (player 2), → GAMEOVER. After 300 pulses → ATTRACT with `winner`=00.
- Button held continuously from reset: one press only. Release and re-press gives a second press. `nRst` low during COUNTDOWN gives ATTRACT and `timer`=0 on the next edge.
- With `MATCH_SEQUENCER_AUTO_SERVE_EN`: no press in READY → COUNTDOWN after 240 pulses.
